// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared control-unit definitions. These are the sequencer state
//            encodings and the status-word bit positions that the sequencer
//            and all instruction decoders use.
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

  // Sequencer state. The decoders see the raw 2-bit value on the state
  // port, so the encodings below are fixed.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC0 = 2'b01,
    ST_EXEC1 = 2'b10,
    ST_EXEC2 = 2'b11
  } cu_state_e;

  // ALU flag vector layout {V,C,N,Z}
  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Status word layout {V,C,N,Z latched, Z live}
  localparam int STATUS_W       = 5;
  localparam int STATUS_Z_LIVE  = 0;
  localparam int STATUS_FLAG_LO = 1;
  localparam int STATUS_FLAG_HI = 4;

  // True for any execute-phase state.
  function automatic logic is_exec(input cu_state_e s);
    return (s != ST_FETCH);
  endfunction

endpackage : cu_pkg
`default_nettype wire

// File: rtl/control_sequencer_status_reg.sv
`default_nettype none
// ============================================================================
// Module   : status_reg
// Purpose  : Latched ALU flag register. It has a load enable and an
//            asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module status_reg
  import cu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [FLAG_W-1:0] d_i,
  output logic [FLAG_W-1:0] q_o
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;

  // When load is enabled, take the new flags. Otherwise keep the old ones.
  always_comb begin
    flags_d = flags_q;
    if (load_i) begin
      flags_d = d_i;
    end
  end

  // Flag storage. Reset clears it at once, without waiting for the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign q_o = flags_q;

endmodule : status_reg
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Microsequencer for the control unit. It fetches instructions
//            into I and walks the execute states using the next-state field
//            from the active decoder. It also latches ALU flags on request
//            and counts retired instructions. It does not decode any
//            instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
  import cu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instr_in,
  input  logic                instr_valid,
  input  logic [1:0]          ns_in,
  input  logic                status_load_in,
  input  logic [FLAG_W-1:0]   alu_flags,
  input  logic                hold,
  output logic                fetch_req,
  output logic [1:0]          state,
  output logic [31:0]         I,
  output logic [STATUS_W-1:0] status,
  output logic [RETIRE_W-1:0] retired
);

  cu_state_e           state_q;
  logic [31:0]         instr_q;
  logic [RETIRE_W-1:0] retired_q;
  logic [RETIRE_W-1:0] retired_d;
  logic [FLAG_W-1:0]   flags_q;

  logic exec_adv;    // an execute state that advances on this edge
  logic retire_now;  // the instruction finishes on this edge
  logic flag_load;   // decoder asked for a flag latch in an active exec cycle

  assign exec_adv   = is_exec(state_q) && !hold;
  assign retire_now = exec_adv && (cu_state_e'(ns_in) == ST_FETCH);
  assign flag_load  = exec_adv && status_load_in;

  // The counter wraps naturally modulo 2^RETIRE_W.
  always_comb begin
    retired_d = retired_q;
    if (retire_now) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  // Sequencer FSM. In FETCH it waits for the fetch acknowledge and captures
  // the instruction. In the exec states it follows the decoder's next state.
  // While hold is high nothing changes. Reset aborts the current instruction
  // without retiring it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      instr_q   <= '0;
      retired_q <= '0;
    end else if (!hold) begin
      case (state_q)
        ST_FETCH: begin
          if (instr_valid) begin
            instr_q <= instr_in;
            state_q <= ST_EXEC0;
          end
        end
        default: begin
          state_q <= cu_state_e'(ns_in);
        end
      endcase
      retired_q <= retired_d;
    end
  end

  status_reg u_status_reg (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (flag_load),
    .d_i    (alu_flags),
    .q_o    (flags_q)
  );

  // Gate the fetch request with reset. During reset the state already reads
  // FETCH, but memory must not see a request.
  assign fetch_req = (state_q == ST_FETCH) && !hold && !reset;

  assign state   = state_q;
  assign I       = instr_q;
  assign retired = retired_q;

  // Live Z lets a compare-and-branch use the current result in the same cycle.
  assign status[STATUS_FLAG_HI:STATUS_FLAG_LO] = flags_q;
  assign status[STATUS_Z_LIVE]                 = alu_flags[FLAG_Z];

endmodule : control_sequencer
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter RETIRE_W, default 16, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port instr_in, input, 32, instruction word from instruction memory.
REQ-005 SHALL have port instr_valid, input, 1, instr_in valid this cycle (fetch acknowledge).
REQ-006 SHALL have port ns_in, input, 2, next-state field from the active instruction decoder.
REQ-007 SHALL have port status_load_in, input, 1, decoder request to latch ALU flags.
REQ-008 SHALL have port alu_flags, input, 4, live ALU flags {V,C,N,Z}.
REQ-009 SHALL have port hold, input, 1, freezes the sequencer (all registers keep value).
REQ-010 SHALL have port fetch_req, output, 1, request to instruction memory.
REQ-011 SHALL have port state, output, 2, current sequencer state, fed to all decoders.
REQ-012 SHALL have port I, output, 32, instruction register, fed to all decoders.
REQ-013 SHALL have port status, output, 5, {V,C,N,Z latched, Z live}.
REQ-014 SHALL have port retired, output, RETIRE_W, count of completed instructions.

Function
REQ-015 SHALL encode state as FETCH=2'b00, EXEC0=2'b01, EXEC1=2'b10, EXEC2=2'b11.
REQ-016 SHALL assert fetch_req combinationally exactly when state==FETCH and hold==0.
REQ-017 SHALL, in FETCH with instr_valid==1 and hold==0, load I<=instr_in and go to EXEC0 next cycle.
REQ-018 SHALL, in FETCH with instr_valid==0, remain in FETCH with I unchanged (no timeout).
REQ-019 SHALL, in any EXEC state with hold==0, take next state = ns_in; ns_in==FETCH ends the instruction.
REQ-020 SHALL ignore instr_valid outside FETCH (no I update).
REQ-021 SHALL increment retired by 1 on each edge where state!=FETCH, hold==0 and ns_in==FETCH; wrap modulo 2^RETIRE_W.
REQ-022 SHALL load status[4:1]<=alu_flags on an edge where state!=FETCH, hold==0 and status_load_in==1; else hold.
REQ-023 SHALL ignore status_load_in in FETCH.
REQ-024 SHALL drive status[0] combinationally equal to alu_flags[0] (unlatched, for compare-and-branch).
REQ-025 SHALL, with hold==1, keep state, I, status[4:1] and retired unchanged and deassert fetch_req.
REQ-026 SHALL accept ns_in==EXEC0 from EXEC0 (self-loop) for multi-cycle operations without limit.
REQ-027 SHALL complete a one-cycle instruction in exactly 2 cycles after instr_valid (FETCH, EXEC0, back to FETCH).

Reset
REQ-028 SHALL on reset assertion immediately force state=FETCH, I=32'h0, status[4:1]=4'b0, retired=0, independent of clock.
REQ-029 SHALL, while reset is high, deassert fetch_req.
REQ-030 SHALL treat reset mid-instruction as abort: no retired increment, no flag load, restart at FETCH after deassertion.
REQ-031 SHALL assert fetch_req on the first cycle after reset deasserts (if hold==0).

Structure
REQ-032 SHALL take the state encodings and status bit positions from the shared control-unit package cu_pkg, also used by decoders.
REQ-033 SHALL instantiate one sub-module status_reg (4-bit flag register with load enable, async reset).
REQ-034 SHALL contain no decode of instruction fields; decoding stays in decoder blocks.

Verification
REQ-035 SHALL cover: reset, instr_valid=1 with instr_in=32'h91000421, ns_in=00 in EXEC0 -> I=32'h91000421, state 00->01->00, retired=1.
REQ-036 SHALL cover: ns_in sequence 10,11,00 from EXEC0 -> states 01,10,11,00, retired increments once, on the EXEC2 exit edge.
REQ-037 SHALL cover: alu_flags=4'b1010, status_load_in=1 in EXEC0 -> status[4:1]=1010; later status_load_in=0 with flags 0101 -> stays 1010; status[0] tracks alu_flags[0] every cycle.
REQ-038 SHALL cover: hold=1 for 3 cycles in EXEC1 -> all outputs frozen, fetch_req=0; resumes with ns_in on first edge after hold=0.
REQ-039 SHALL cover: reset pulsed asynchronously in EXEC1 -> state=00, I=0, status=0, retired=0 before next clock edge.
REQ-040 SHALL cover: RETIRE_W=4, 16 instructions retired -> retired wraps from 4'hF to 4'h0.
